// File: rtl/amber48_fetch.sv
// amber48_fetch: holds the fetch PC, issues credit-limited in-order imem reads and buffers responses for the decoder.
// Optional: define AMBER48_FETCH_PERF_EN to add fetch_bubble_cnt_o (decoder-starved cycle counter).
package amber48_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 48;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } amber48_decode_in_s;
endpackage

module amber48_fetch
  import amber48_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(0),
  parameter logic [XLEN-1:0] PC_STEP   = XLEN'(1),
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               imem_req_o,
  output logic [XLEN-1:0]    imem_addr_o,
  input  logic               imem_ready_i,
  input  logic               imem_rvalid_i,
  input  logic [ILEN-1:0]    imem_rdata_i,
  input  logic               redirect_valid_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  input  logic               decode_ready_i,
  output amber48_decode_in_s fetch_o
`ifdef AMBER48_FETCH_PERF_EN
  ,
  output logic [31:0]        fetch_bubble_cnt_o
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(BUF_DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(BUF_DEPTH - 1);

  typedef enum logic [0:0] {RUN, DRAIN} state_e;

  state_e                         state_q, state_d;
  logic [XLEN-1:0]                pc_q, pc_d;
  logic [CW-1:0]                  inflight_q, inflight_d;
  logic [CW-1:0]                  drop_q, drop_d;
  logic [CW-1:0]                  fcnt_q, fcnt_d;
  logic [AW-1:0]                  frd_q, frd_d, fwr_q, fwr_d;
  logic [AW-1:0]                  qrd_q, qrd_d, qwr_q, qwr_d;
  logic [BUF_DEPTH-1:0][XLEN-1:0] fpc_q, fpc_d;
  logic [BUF_DEPTH-1:0][ILEN-1:0] finstr_q, finstr_d;
  logic [BUF_DEPTH-1:0][XLEN-1:0] qpc_q, qpc_d;

  logic [CW:0] occupancy;
  logic        req, accept, fvalid, pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // Slots already promised (in flight) plus slots holding data bound the
  // request window, so every response is guaranteed a FIFO entry.
  always_comb begin
    occupancy = {1'b0, inflight_q} + {1'b0, fcnt_q};
    req       = rst_ni && (state_q == RUN) && !redirect_valid_i && (occupancy < DEPTH_C);
    accept    = req && imem_ready_i;
    fvalid    = (fcnt_q != '0) && !redirect_valid_i;
    pop       = fvalid && decode_ready_i;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    fcnt_d     = fcnt_q;
    frd_d      = frd_q;
    fwr_d      = fwr_q;
    qrd_d      = qrd_q;
    qwr_d      = qwr_q;
    fpc_d      = fpc_q;
    finstr_d   = finstr_q;
    qpc_d      = qpc_q;
    case (state_q)
      RUN: begin
        if (redirect_valid_i) begin
          // A response landing this cycle is already gone, so it is not owed a drop.
          pc_d       = redirect_pc_i;
          drop_d     = inflight_q - CW'(imem_rvalid_i);
          inflight_d = '0;
          fcnt_d     = '0;
          frd_d      = '0;
          fwr_d      = '0;
          qrd_d      = '0;
          qwr_d      = '0;
          state_d    = (drop_d != '0) ? DRAIN : RUN;
        end else begin
          if (accept) begin
            qpc_d[qwr_q] = pc_q;
            qwr_d        = ptr_inc(qwr_q);
            pc_d         = pc_q + PC_STEP;
          end
          if (imem_rvalid_i) begin
            fpc_d[fwr_q]    = qpc_q[qrd_q];
            finstr_d[fwr_q] = imem_rdata_i;
            fwr_d           = ptr_inc(fwr_q);
            qrd_d           = ptr_inc(qrd_q);
          end
          if (pop) frd_d = ptr_inc(frd_q);
          inflight_d = inflight_q + CW'(accept) - CW'(imem_rvalid_i);
          fcnt_d     = fcnt_q + CW'(imem_rvalid_i) - CW'(pop);
        end
      end
      DRAIN: begin
        if (redirect_valid_i) pc_d = redirect_pc_i;
        if (imem_rvalid_i)    drop_d = drop_q - 1'b1;
        state_d = (drop_d == '0) ? RUN : DRAIN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      fcnt_q     <= '0;
      frd_q      <= '0;
      fwr_q      <= '0;
      qrd_q      <= '0;
      qwr_q      <= '0;
      fpc_q      <= '0;
      finstr_q   <= '0;
      qpc_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      fcnt_q     <= fcnt_d;
      frd_q      <= frd_d;
      fwr_q      <= fwr_d;
      qrd_q      <= qrd_d;
      qwr_q      <= qwr_d;
      fpc_q      <= fpc_d;
      finstr_q   <= finstr_d;
      qpc_q      <= qpc_d;
    end
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = pc_q;
  assign fetch_o.valid = fvalid;
  assign fetch_o.pc    = fvalid ? fpc_q[frd_q]    : '0;
  assign fetch_o.instr = fvalid ? finstr_q[frd_q] : '0;

`ifdef AMBER48_FETCH_PERF_EN
  logic [31:0] bubble_q, bubble_d;

  always_comb begin
    bubble_d = bubble_q;
    if (decode_ready_i && !fvalid && (bubble_q != 32'hFFFF_FFFF)) bubble_d = bubble_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) bubble_q <= '0;
    else         bubble_q <= bubble_d;
  end

  assign fetch_bubble_cnt_o = bubble_q;
`endif

  // In DRAIN the outstanding responses are tracked by drop, not inflight.
  logic [CW-1:0] outstanding;
  assign outstanding = (state_q == RUN) ? inflight_q : drop_q;

  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rvalid_i |-> (outstanding != '0));

endmodule

// File: tb/tb_amber48_fetch.sv
// Randomized bench for amber48_fetch: queue-based reference model of the fetch pipeline plus an in-order imem model.
module tb_amber48_fetch;
  import amber48_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h100;
  localparam logic [31:0] STEP  = 32'h1;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               imem_req_o;
  logic [31:0]        imem_addr_o;
  logic               imem_ready_i = 1'b0;
  logic               imem_rvalid_i = 1'b0;
  logic [47:0]        imem_rdata_i = '0;
  logic               redirect_valid_i = 1'b0;
  logic [31:0]        redirect_pc_i = '0;
  logic               decode_ready_i = 1'b0;
  amber48_decode_in_s fetch_o;
`ifdef AMBER48_FETCH_PERF_EN
  logic [31:0]        fetch_bubble_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  amber48_fetch #(.RESET_PC(RPC), .PC_STEP(STEP), .BUF_DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_ready_i     (imem_ready_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .decode_ready_i   (decode_ready_i),
    .fetch_o          (fetch_o)
`ifdef AMBER48_FETCH_PERF_EN
    ,
    .fetch_bubble_cnt_o (fetch_bubble_cnt_o)
`endif
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a};
  endfunction

  // Reference model: architectural PC, PCs awaiting a response, buffered
  // instructions, and responses still to be thrown away after a redirect.
  typedef struct { logic [31:0] pc; logic [47:0] instr; } ent_t;
  typedef struct { int due; logic [31:0] addr; } rsp_t;
  logic [31:0] m_pc;
  logic [31:0] m_infl[$];
  ent_t        m_fifo[$];
  int          m_drop;
  logic [31:0] m_bub;
  rsp_t        imq[$];
  int          cyc, last_due;
  int          lat_min = 1, lat_max = 1, p_rdy = 100, p_drdy = 100, p_redir = 0;
  int          first_acc, first_val;

  task automatic drive();
    int r;
    imem_ready_i     = ($urandom_range(99) < p_rdy);
    decode_ready_i   = ($urandom_range(99) < p_drdy);
    redirect_valid_i = ($urandom_range(99) < p_redir);
    r = $urandom_range(3);
    redirect_pc_i    = (r == 0) ? 32'hFFFF_FFFF - $urandom_range(2) : 32'($urandom_range(16'hFFFF));
    imem_rvalid_i    = (imq.size() > 0) && (imq[0].due <= cyc);
    imem_rdata_i     = imem_rvalid_i ? instr_of(imq[0].addr) : {16'($urandom), $urandom};
  endtask

  task automatic step();
    bit   mreq, mval;
    ent_t e;
    rsp_t rs;
    @(negedge clk_i);
    mreq = (m_drop == 0) && !redirect_valid_i && (m_infl.size() + m_fifo.size() < DEPTH);
    mval = (m_fifo.size() > 0) && !redirect_valid_i;
    chk("req", imem_req_o, mreq);
    if (mreq) chk("addr", imem_addr_o, m_pc);
    chk("valid", fetch_o.valid, mval);
    if (mval) begin
      chk("pc", fetch_o.pc, m_fifo[0].pc);
      chk("instr", fetch_o.instr, m_fifo[0].instr);
    end
`ifdef AMBER48_FETCH_PERF_EN
    chk("bubble", fetch_bubble_cnt_o, m_bub);
`endif
    if (first_acc < 0 && imem_req_o && imem_ready_i) first_acc = cyc;
    if (first_val < 0 && fetch_o.valid) first_val = cyc;
    @(posedge clk_i);
    if (decode_ready_i && !mval && m_bub != 32'hFFFF_FFFF) m_bub++;
    if (redirect_valid_i) begin
      if (m_drop == 0) m_drop = m_infl.size() - (imem_rvalid_i ? 1 : 0);
      else if (imem_rvalid_i) m_drop--;
      m_infl.delete();
      m_fifo.delete();
      m_pc = redirect_pc_i;
    end else if (m_drop > 0) begin
      if (imem_rvalid_i) m_drop--;
    end else begin
      if (mval && decode_ready_i) void'(m_fifo.pop_front());
      if (imem_rvalid_i && m_infl.size() > 0) begin
        e.pc    = m_infl.pop_front();
        e.instr = imem_rdata_i;
        m_fifo.push_back(e);
      end
      if (mreq && imem_ready_i) begin
        m_infl.push_back(m_pc);
        m_pc += STEP;
      end
    end
    if (imem_rvalid_i) void'(imq.pop_front());
    if (mreq && imem_ready_i) begin
      rs.due  = cyc + $urandom_range(lat_max, lat_min);
      if (rs.due <= last_due) rs.due = last_due + 1;
      rs.addr = m_pc - STEP;
      if (redirect_valid_i) rs.addr = imem_addr_o;
      last_due = rs.due;
      imq.push_back(rs);
    end
    cyc++;
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    imem_ready_i = 1'b0; imem_rvalid_i = 1'b0; redirect_valid_i = 1'b0; decode_ready_i = 1'b0;
    m_pc = RPC; m_infl.delete(); m_fifo.delete(); m_drop = 0; m_bub = '0;
    imq.delete(); cyc = 0; last_due = -1; first_acc = -1; first_val = -1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    drive();
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      seen = fetch_o.valid && !redirect_valid_i;
    end
    chk({tag, "_seen"}, seen, 1);
    if (seen) chk(tag, fetch_o.pc, exp_pc);
  endtask

  initial begin
    // 1: straight-line fetch, 1-cycle imem
    lat_min = 1; lat_max = 1; p_rdy = 100; p_drdy = 100; p_redir = 0;
    do_reset();
    chk("rst_addr", imem_addr_o, RPC);
    repeat (20) step();
    chk("first_lat", 64'(first_val - first_acc), 2);

    // 2: decoder stall, then release
    p_drdy = 0;
    repeat (5) step();
    p_drdy = 100;
    repeat (10) step();

    // 3: redirect with two responses in flight on a 3-cycle imem
    lat_min = 3; lat_max = 3;
    begin
      bit hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
        step();
        hit = (m_infl.size() == 2) && !imem_rvalid_i && (m_drop == 0);
      end
      chk("inflight2_seen", hit, 1);
    end
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h400;
    step();
    chk("drain_cnt", m_drop, 2);
    wait_valid("redir400_pc", 32'h400);

    // 4: redirect colliding with a response and a pop
    lat_min = 1; lat_max = 1;
    begin
      bit hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
        step();
        hit = imem_rvalid_i && (m_fifo.size() > 0) && decode_ready_i && (m_drop == 0);
      end
      chk("collide_seen", hit, 1);
    end
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h800;
    step();
    wait_valid("redir800_pc", 32'h800);

    // 5: imem back-pressure, PC wrap
    redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
    step();
    p_rdy = 0;
    repeat (4) begin
      imem_ready_i = 1'b0;
      step();
    end
    chk("held_addr", imem_addr_o, 32'hFFFF_FFFE);
    p_rdy = 100;
    wait_valid("wrap_pc0", 32'hFFFF_FFFE);
    repeat (10) step();
    chk("wrap_addr_small", imem_addr_o < 32'h10, 1);

    // random soak
    lat_min = 1; lat_max = 4; p_rdy = 70; p_drdy = 70; p_redir = 5;
    repeat (3000) step();

    // 6: starvation counter and asynchronous reset mid-run
    p_redir = 0;
    do_reset();
    p_rdy = 0; p_drdy = 100;
    imem_ready_i = 1'b0; decode_ready_i = 1'b1;
    repeat (7) step();
`ifdef AMBER48_FETCH_PERF_EN
    chk("bubble7", fetch_bubble_cnt_o, 7);
`endif
    p_rdy = 80; p_drdy = 60; lat_max = 2;
    repeat (12) step();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_req", imem_req_o, 0);
    chk("arst_valid", fetch_o.valid, 0);
    chk("arst_pc", fetch_o.pc, 0);
    chk("arst_instr", fetch_o.instr, 0);
    chk("arst_addr", imem_addr_o, RPC);
`ifdef AMBER48_FETCH_PERF_EN
    chk("arst_bubble", fetch_bubble_cnt_o, 0);
`endif
    do_reset();
    p_rdy = 100; p_drdy = 100; lat_max = 1;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
